// File: rtl/gpr_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpr_pkg
// Brief    : Shared constants and helpers for the GPR writeback arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package gpr_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [63:0] ZERO_WORD = 64'd0;

  // Writeback source indices on the arbiter request vector
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_CSR = 2;

  // One-hot decode of a register index; index 0 never maps to a bit so that
  // x0 can never become pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (addr != '0) v[addr] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Returns the first requester at
//            or after ptr (mod N) as one-hot grant plus its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  logic [IW:0] w_sum;
  logic [IW-1:0] w_idx;

  // Scan N candidates starting at ptr with wraparound; first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtract implements mod N
      w_sum = {1'b0, ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_idx = w_sum[IW-1:0];
      if (!any_grant && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
        any_grant    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_wb_arbiter
// Brief    : Round-robin sharing of the single GPR write port among N_SRC
//            writeback sources, registered write port, and a per-register
//            pending-write scoreboard for RAW stall detection.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int N_SRC      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0]              req_valid,
  output logic [N_SRC-1:0]              req_ready,
  input  logic [N_SRC*REG_ADDR_W-1:0]   req_addr,
  input  logic [N_SRC*DATA_WIDTH-1:0]   req_data,
  output logic                          gpr_wen,
  output logic [REG_ADDR_W-1:0]         gpr_waddr,
  output logic [DATA_WIDTH-1:0]         gpr_wdata,
  input  logic                          alloc_en,
  input  logic [REG_ADDR_W-1:0]         alloc_addr,
  input  logic [REG_ADDR_W-1:0]         q_addr1,
  input  logic [REG_ADDR_W-1:0]         q_addr2,
  output logic                          busy1,
  output logic                          busy2,
  input  logic                          flush,
  output logic                          alloc_err
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PW-1:0]         r_rr_ptr;
  logic [NUM_REGS-1:0]   r_busy;

  logic [N_SRC-1:0]      w_req;
  logic [N_SRC-1:0]      w_grant;
  logic [PW-1:0]         w_gidx;
  logic                  w_any;
  logic [REG_ADDR_W-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;
  logic [NUM_REGS-1:0]   w_busy_nxt;
  logic                  w_alloc_err;

  // Nothing is granted while reset is held, so no source sees a handshake
  assign w_req     = req_valid & {N_SRC{rst}};
  assign req_ready = w_grant;

  rr_arbiter #(
    .N  (N_SRC),
    .IW (PW)
  ) u_rr (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx),
    .any_grant (w_any)
  );

  // Select the granted source's address and data from the packed buses
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Register the winning write; x0 writes are accepted but never enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= DATA_WIDTH'(ZERO_WORD);
      r_rr_ptr  <= '0;
    end else begin
      gpr_wen <= w_any && (w_sel_addr != '0);
      if (w_any && (w_sel_addr != '0)) begin
        gpr_waddr <= w_sel_addr;
        gpr_wdata <= w_sel_data;
      end
      if (w_any) begin
        r_rr_ptr <= (w_gidx == PW'(N_SRC-1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

  // Scoreboard next state: commit clears, alloc sets and beats any clear/flush
  always_comb begin
    w_set       = alloc_en ? reg_onehot(alloc_addr) : '0;
    w_clr       = gpr_wen  ? reg_onehot(gpr_waddr)  : '0;
    w_busy_nxt  = flush ? w_set : ((r_busy & ~w_clr) | w_set);
    w_busy_nxt[0] = 1'b0;
    // A bit that is about to be cleared (commit or flush) is a legal re-alloc
    w_alloc_err = alloc_en && (alloc_addr != '0) && r_busy[alloc_addr]
                  && !w_clr[alloc_addr] && !flush;
  end

  // Scoreboard state and alloc error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= '0;
      alloc_err <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      alloc_err <= w_alloc_err;
    end
  end

  assign busy1 = r_busy[q_addr1];
  assign busy2 = r_busy[q_addr2];

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpr_wb_arbiter
// Brief    : Directed self-checking bench for gpr_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

  localparam int DW = 64;
  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   req_valid;
  logic [NS-1:0]   req_ready;
  logic [NS*5-1:0] req_addr;
  logic [NS*DW-1:0] req_data;
  logic            gpr_wen;
  logic [4:0]      gpr_waddr;
  logic [DW-1:0]   gpr_wdata;
  logic            alloc_en;
  logic [4:0]      alloc_addr;
  logic [4:0]      q_addr1;
  logic [4:0]      q_addr2;
  logic            busy1;
  logic            busy2;
  logic            flush;
  logic            alloc_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.DATA_WIDTH(DW), .N_SRC(NS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gpr_wen    (gpr_wen),
    .gpr_waddr  (gpr_waddr),
    .gpr_wdata  (gpr_wdata),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .q_addr1    (q_addr1),
    .q_addr2    (q_addr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .flush      (flush),
    .alloc_err  (alloc_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    req_valid[i]         = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; q_addr1 = 5'd5; q_addr2 = 5'd0; flush = 1'b0;
    set_src(0, 1'b1, 5'd5, 64'hA);
    set_src(1, 1'b1, 5'd6, 64'hB);
    set_src(2, 1'b1, 5'd7, 64'hC);

    // Reset held with all sources requesting
    tick(); tick();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wen",   64'(gpr_wen),   64'd0);
    chk("rst_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_wdata", gpr_wdata,      64'd0);
    chk("rst_busy",  64'(busy1),     64'd0);
    chk("rst_err",   64'(alloc_err), 64'd0);

    // Release reset away from the rising edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_ready", 64'(req_ready), 64'b001);

    // Continuous requests: grants rotate 0,1,2,0
    tick();
    chk("rr_wen0",   64'(gpr_wen),   64'd1);
    chk("rr_addr0",  64'(gpr_waddr), 64'd5);
    chk("rr_data0",  gpr_wdata,      64'hA);
    chk("rr_ready1", 64'(req_ready), 64'b010);
    tick();
    chk("rr_addr1",  64'(gpr_waddr), 64'd6);
    chk("rr_data1",  gpr_wdata,      64'hB);
    chk("rr_ready2", 64'(req_ready), 64'b100);
    tick();
    chk("rr_addr2",  64'(gpr_waddr), 64'd7);
    chk("rr_data2",  gpr_wdata,      64'hC);
    chk("rr_ready3", 64'(req_ready), 64'b001);
    tick();
    chk("rr_addr3",  64'(gpr_waddr), 64'd5);
    chk("rr_ready4", 64'(req_ready), 64'b010);
    req_valid = '0;                     // withdrawn before the edge: no grant
    tick();
    chk("idle_wen",  64'(gpr_wen),   64'd0);
    chk("idle_hold", 64'(gpr_waddr), 64'd5);

    // Scoreboard: alloc 9, then LSU writes 9
    alloc_en = 1'b1; alloc_addr = 5'd9; q_addr1 = 5'd9;
    #1;
    chk("sb9_nobypass", 64'(busy1), 64'd0);
    tick();
    alloc_en = 1'b0;
    chk("sb9_set", 64'(busy1), 64'd1);
    set_src(1, 1'b1, 5'd9, 64'h1234);
    #1;
    chk("sb9_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    chk("sb9_wen",   64'(gpr_wen),   64'd1);
    chk("sb9_waddr", 64'(gpr_waddr), 64'd9);
    chk("sb9_wdata", gpr_wdata,      64'h1234);
    chk("sb9_busy_during", 64'(busy1), 64'd1);
    tick();
    chk("sb9_busy_after", 64'(busy1), 64'd0);
    chk("sb9_wen_off",    64'(gpr_wen), 64'd0);

    // x0 write: accepted, never enabled, never busy
    set_src(0, 1'b1, 5'd0, 64'hFFFF);
    q_addr2 = 5'd0;
    #1;
    chk("x0_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk("x0_wen",  64'(gpr_wen), 64'd0);
    chk("x0_busy", 64'(busy2),   64'd0);

    // Set/clear collision on 12, then double alloc error
    alloc_en = 1'b1; alloc_addr = 5'd12; q_addr1 = 5'd12;
    tick();
    alloc_en = 1'b0;
    set_src(0, 1'b1, 5'd12, 64'h55);
    #1;
    chk("c12_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk("c12_wen", 64'(gpr_wen), 64'd1);
    alloc_en = 1'b1; alloc_addr = 5'd12;
    tick();
    alloc_en = 1'b0;
    chk("c12_busy_kept", 64'(busy1),     64'd1);
    chk("c12_no_err",    64'(alloc_err), 64'd0);
    alloc_en = 1'b1; alloc_addr = 5'd12;
    tick();
    alloc_en = 1'b0;
    chk("c12_err_pulse", 64'(alloc_err), 64'd1);
    chk("c12_busy",      64'(busy1),     64'd1);
    tick();
    chk("c12_err_clear", 64'(alloc_err), 64'd0);

    // Flush with a write to 3 in flight and a same-cycle alloc of 4
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    alloc_addr = 5'd4;
    tick();
    alloc_en = 1'b0; q_addr1 = 5'd3; q_addr2 = 5'd4;
    #1;
    chk("fl_busy3", 64'(busy1), 64'd1);
    chk("fl_busy4", 64'(busy2), 64'd1);
    set_src(1, 1'b1, 5'd3, 64'h33);
    #1;
    chk("fl_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd4;
    chk("fl_wen",   64'(gpr_wen),   64'd1);
    chk("fl_waddr", 64'(gpr_waddr), 64'd3);
    chk("fl_wdata", gpr_wdata,      64'h33);
    tick();
    flush = 1'b0; alloc_en = 1'b0;
    chk("fl_busy3_clr",  64'(busy1), 64'd0);
    chk("fl_busy4_kept", 64'(busy2), 64'd1);
    q_addr1 = 5'd12;
    #1;
    chk("fl_busy12_clr", 64'(busy1), 64'd0);

    // Asynchronous reset drops an in-flight write and clears the scoreboard
    set_src(0, 1'b1, 5'd7, 64'h77);
    tick();
    req_valid = '0;
    chk("ar_wen_before", 64'(gpr_wen), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_wen_dropped", 64'(gpr_wen), 64'd0);
    chk("ar_busy4_clr",   64'(busy2),   64'd0);
    chk("ar_waddr",       64'(gpr_waddr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
